// File: rtl/seg_pkg.sv
// Segment encodings and digit-select constants shared by the display driver and the scan decoder.
package seg_pkg;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [2:0] WEI_GE  = 3'b001;
    localparam logic [2:0] WEI_SHI = 3'b010;
    localparam logic [2:0] WEI_BAI = 3'b100;

    // Indexed by BCD value: SEG_TABLE[n] is the active-low code for digit n.
    localparam logic [9:0][7:0] SEG_TABLE = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                             SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

    typedef struct packed {
        logic [2:0] wei;
        logic [7:0] data;
    } scan_pair_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational reverse lookup: active-low segment pattern (dp excluded) -> BCD digit.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] bcd
);

    logic [7:0] code;

    always_comb begin
        hit  = 1'b0;
        bcd  = 4'd0;
        code = 8'h00;
        for (int i = 0; i < 10; i++) begin
            code = SEG_TABLE[i];
            if (seg == code[6:0]) begin
                hit = 1'b1;
                bcd = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed 7-segment bus: debounces the scan, decodes digits
// back to BCD and republishes each complete 3-digit frame.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CNT = 8,
    parameter int TIMEOUT    = 1000000
) (
    input  logic       clk,
    input  logic       res,
    input  logic [7:0] data,
    input  logic [2:0] wei,
    output logic [3:0] ge_o,
    output logic [3:0] shi_o,
    output logic [3:0] bai_o,
    output logic       valid,
    output logic       frame_done,
    output logic       err,
    output logic [2:0] err_wei
);

    localparam int SW = $clog2(STABLE_CNT);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STB_MAX = SW'(STABLE_CNT - 1);
    localparam logic [SW-1:0] STB_PRE = SW'(STABLE_CNT - 2);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_PRE  = TW'(TIMEOUT - 2);

    scan_pair_t    pair_p1, pair_p2;
    logic [SW-1:0] stb_cnt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    dig_ge, dig_shi, dig_bai;
    logic [2:0]    seen, seen_nxt;
    logic          hit;
    logic [3:0]    bcd;
    logic          same, accept, wei_ok, blank, acc_digit, acc_err, complete, to_fire;

    seg7_decode u_dec (
        .seg (pair_p2.data[6:0]),
        .hit (hit),
        .bcd (bcd)
    );

    // pair_p1 is the value pair_p2 takes next, so a mismatch clears the run
    // on the same edge the stage-2 value changes.
    assign same      = (pair_p1 == pair_p2);
    assign accept    = same && (stb_cnt == STB_PRE);
    assign wei_ok    = $onehot(pair_p2.wei);
    assign blank     = (pair_p2.data == SEG_BLANK);
    assign acc_digit = accept && wei_ok && !blank && hit;
    assign acc_err   = accept && wei_ok && !blank && !hit;
    assign complete  = (seen == 3'b111);
    assign to_fire   = (to_cnt == TO_PRE) && !(acc_digit || acc_err);

    always_comb begin
        seen_nxt = seen;
        if (complete || to_fire) begin
            seen_nxt = 3'b000;
        end
        if (acc_digit) begin
            seen_nxt = seen_nxt | pair_p2.wei;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            pair_p1    <= '0;
            pair_p2    <= '0;
            stb_cnt    <= '0;
            to_cnt     <= '0;
            dig_ge     <= 4'd0;
            dig_shi    <= 4'd0;
            dig_bai    <= 4'd0;
            seen       <= 3'b000;
            ge_o       <= 4'd0;
            shi_o      <= 4'd0;
            bai_o      <= 4'd0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            err_wei    <= 3'b000;
        end else begin
            // p1/p2: two-stage input capture
            pair_p1 <= {wei, data};
            pair_p2 <= pair_p1;

            // stability filter on the stage-2 pair
            if (!same) begin
                stb_cnt <= '0;
            end else if (stb_cnt != STB_MAX) begin
                stb_cnt <= stb_cnt + 1'b1;
            end

            if (acc_digit) begin
                if (pair_p2.wei == WEI_GE)  dig_ge  <= bcd;
                if (pair_p2.wei == WEI_SHI) dig_shi <= bcd;
                if (pair_p2.wei == WEI_BAI) dig_bai <= bcd;
            end
            seen <= seen_nxt;

            if (acc_digit || acc_err) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end

            err <= acc_err;
            if (acc_err) begin
                err_wei <= pair_p2.wei;
            end

            // frame output stage: completion outranks a coincident timeout
            frame_done <= complete;
            if (complete) begin
                ge_o  <= dig_ge;
                shi_o <= dig_shi;
                bai_o <= dig_bai;
                valid <= 1'b1;
            end else if (to_fire) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
